multicycle_controller: RTL

Main control FSM for the multicycle RV32I core. It decodes the opcode held in the instruction register and sequences fetch, decode, execute, memory and writeback over several cycles. Each cycle it drives the datapath selects and write enables, including `immsrc` to the immediate extender and `aluop` to the ALU decoder. It also handles the instruction/data memory ready handshake.

---
 rtl/multicycle_controller.sv | 179 +++++++++++++++++
 1 files changed

// File: rtl/multicycle_controller.sv
// Main control FSM of the multicycle RV32I core: sequences fetch, decode, execute,
// memory and writeback, driving datapath selects and write enables each cycle.
module multicycle_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] immsrc,
  output logic [1:0] alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] resultsrc,
  output logic       adrsrc,
  output logic       irwrite,
  output logic       pcwrite,
  output logic       regwrite,
  output logic       memwrite,
  output logic       illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  typedef enum logic [3:0] {
    S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE, S_EXECR,
    S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC
  } state_t;

  state_t state, state_next;
  logic   pcupdate, branch, ir_en, reg_en, mem_en, ill;
  logic   taken;

  always_ff @(posedge clk) begin
    if (reset) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    case (op)
      OP_STORE:        immsrc = 3'b001;
      OP_BRANCH:       immsrc = 3'b010;
      OP_JAL:          immsrc = 3'b011;
      OP_LUI, OP_AUIPC: immsrc = 3'b100;
      default:         immsrc = 3'b000;
    endcase
  end

  // Only beq/bne are decoded; other branch funct3 values fall through as not taken.
  always_comb begin
    case (funct3)
      3'b000:  taken = zero;
      3'b001:  taken = ~zero;
      default: taken = 1'b0;
    endcase
  end

  always_comb begin
    state_next = state;
    alusrca    = 2'b00;
    alusrcb    = 2'b00;
    aluop      = 2'b00;
    resultsrc  = 2'b00;
    adrsrc     = 1'b0;
    pcupdate   = 1'b0;
    branch     = 1'b0;
    ir_en      = 1'b0;
    reg_en     = 1'b0;
    mem_en     = 1'b0;
    ill        = 1'b0;
    case (state)
      S_FETCH: begin
        alusrcb   = 2'b10;
        resultsrc = 2'b10;
        if (mem_ready) begin
          ir_en      = 1'b1;
          pcupdate   = 1'b1;
          state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        alusrca = 2'b01;
        alusrcb = 2'b01;
        case (op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          OP_AUIPC:          state_next = S_AUIPC;
          default: begin
            ill        = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        state_next = (op == OP_LOAD) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        adrsrc = 1'b1;
        if (mem_ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        resultsrc  = 2'b01;
        reg_en     = 1'b1;
        state_next = S_FETCH;
      end
      S_MEMWRITE: begin
        adrsrc = 1'b1;
        mem_en = 1'b1;
        if (mem_ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        alusrca    = 2'b10;
        aluop      = 2'b10;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        aluop      = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        reg_en     = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        alusrca    = 2'b10;
        aluop      = 2'b01;
        branch     = 1'b1;
        state_next = S_FETCH;
      end
      S_JALR: begin
        alusrca    = 2'b10;
        alusrcb    = 2'b01;
        state_next = S_JAL;
      end
      S_JAL: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b10;
        pcupdate   = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        alusrca    = 2'b11;
        alusrcb    = 2'b01;
        state_next = S_ALUWB;
      end
      S_AUIPC: begin
        alusrca    = 2'b01;
        alusrcb    = 2'b01;
        state_next = S_ALUWB;
      end
      default: state_next = S_FETCH;
    endcase
  end

  // Reset suppresses every write so an aborted instruction leaves no side effects.
  assign irwrite  = ~reset & ir_en;
  assign pcwrite  = ~reset & (pcupdate | (branch & taken));
  assign regwrite = ~reset & reg_en;
  assign memwrite = ~reset & mem_en;
  assign illegal  = ~reset & ill;

endmodule
